// File: rtl/shift_add_mul.sv
// 16x16 unsigned sequential multiplier: one shift-add step per cycle, fixed 16-step latency,
// valid/ready handshake on both the operand and product sides.
module shift_add_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [4:0]  count_q, count_d;
  logic [16:0] sum;

  // The carry of the add is kept as bit 16 and shifted into hi, so no product bit is lost.
  always_comb begin
    if (lo_q[0]) begin
      sum = {1'b0, hi_q} + {1'b0, mcand_q};
    end else begin
      sum = {1'b0, hi_q};
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = op_a;
          lo_d    = op_b;
          hi_d    = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d    = sum[16:1];
        lo_d    = {sum[0], lo_q[15:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed self-checking bench for shift_add_mul: table of operand/product vectors plus
// hand-written sequences for backpressure, ignored input, mid-run reset and back-to-back ops.
module tb_shift_add_mul;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int unsigned n_tests;
  int unsigned n_fail;

  shift_add_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int unsigned hold;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the block idle; returns just after the handshake edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input int unsigned hold);
    int unsigned lat;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = 16'hDEAD;
    op_b     = 16'hBEEF;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat - 1, 32'd16);
    check("product", product, exp);
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {out_valid, in_ready, busy, 29'd0, product != exp},
            {1'b1, 1'b0, 1'b1, 29'd0, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;

    vecs[0] = '{a: 16'd3,     b: 16'd5,     exp: 32'h0000000F, hold: 0};
    vecs[1] = '{a: 16'hFFFF,  b: 16'hFFFF,  exp: 32'hFFFE0001, hold: 0};
    vecs[2] = '{a: 16'h8000,  b: 16'd2,     exp: 32'h00010000, hold: 0};
    vecs[3] = '{a: 16'h0000,  b: 16'h1234,  exp: 32'h00000000, hold: 0};
    vecs[4] = '{a: 16'h1234,  b: 16'h0000,  exp: 32'h00000000, hold: 0};
    vecs[5] = '{a: 16'hABCD,  b: 16'd1,     exp: 32'h0000ABCD, hold: 0};
    vecs[6] = '{a: 16'h1234,  b: 16'h5678,  exp: 32'h06260060, hold: 0};
    vecs[7] = '{a: 16'h8000,  b: 16'h8000,  exp: 32'h40000000, hold: 0};
    vecs[8] = '{a: 16'd100,   b: 16'd100,   exp: 32'h00002710, hold: 10};
    vecs[9] = '{a: 16'hFFFF,  b: 16'd1,     exp: 32'h0000FFFF, hold: 0};

    tick();
    tick();
    check("reset_outputs", {in_ready, out_valid, busy, 29'd0}, {1'b1, 1'b0, 1'b0, 29'd0});
    check("reset_product", product, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
    end

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("out_ready_idle", {30'd0, in_ready, out_valid}, 32'd2);

    // in_valid pulse during RUN at count 7 is ignored
    begin
      int unsigned lat;
      op_a     = 16'h1111;
      op_b     = 16'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int unsigned i = 0; i < 7; i++) tick();
      op_a     = 16'hFFFF;
      op_b     = 16'hFFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("ignored_busy", {31'd0, busy}, 32'd1);
      lat = 8;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check("ignored_latency", lat, 32'd16);
      check("ignored_product", product, 32'h00003333);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // reset at count 9 discards the operation; next accept right after deassertion
    op_a     = 16'h00FF;
    op_b     = 16'h0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned i = 0; i < 9; i++) tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check("midreset_state", {in_ready, out_valid, busy, 29'd0}, {1'b1, 1'b0, 1'b0, 29'd0});
    check("midreset_product", product, 32'd0);
    do_op(16'd7, 16'd9, 32'd63, 0);

    // back-to-back: in_valid held with three queued pairs, out_ready held high
    begin
      logic [15:0] qa[3];
      logic [15:0] qb[3];
      logic [31:0] qe[3];
      int unsigned acc_cyc[3];
      int unsigned idx;
      int unsigned outs;
      int unsigned cyc;
      qa = '{16'd3, 16'hFFFF, 16'h1234};
      qb = '{16'd5, 16'hFFFF, 16'h5678};
      qe = '{32'h0000000F, 32'hFFFE0001, 32'h06260060};
      idx       = 0;
      outs      = 0;
      cyc       = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_a      = qa[0];
      op_b      = qb[0];
      while (outs < 3 && cyc < 200) begin
        logic take;
        take = in_ready && in_valid && idx < 3;
        if (take) acc_cyc[idx] = cyc + 1;
        tick();
        cyc++;
        if (take) begin
          idx++;
          if (idx < 3) begin
            op_a = qa[idx];
            op_b = qb[idx];
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid && outs < 3) begin
          check("b2b_product", product, qe[outs]);
          outs++;
        end
      end
      check("b2b_done_in_time", outs, 32'd3);
      if (outs == 3) begin
        check("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 32'd18);
        check("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 32'd18);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
